// File: rtl/display_mux_n_if.sv
// Bus bundle between a datapath/debug source and the scanned seven-segment driver.
interface display_mux_n_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] din;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   ans;
    logic                    frame_done;

    modport master (
        output din, dp_in, load, blank_lz, blink_mask,
        input  seg, dp, ans, frame_done
    );

    modport slave (
        input  din, dp_in, load, blank_lz, blink_mask,
        output seg, dp, ans, frame_done
    );
endinterface

// File: rtl/display_mux_n.sv
// Scanned N-digit seven-segment driver with tear-free shadow load, per-digit
// decimal points, leading-zero blanking, per-digit blink and frame-done strobe.
module display_mux_n #(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 100000,
    parameter int BLINK_FRAMES     = 32,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    display_mux_n_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] ANS_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [DW-1:0]         act_q, act_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0] actdp_q, actdp_d, penddp_q, penddp_d;
    logic                  pv_q, pv_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] ans_q, ans_d;
    logic                  fd_q;

    logic                  tick, wrap;
    logic [NUM_DIGITS-1:0] upper_zero;   // nibbles k..N-1 of active all zero
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_uz, cur_bm, blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0111111;  4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;  4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;  4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;  4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;  4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;  default: hex7 = 7'b1110001;
        endcase
    endfunction

    assign tick = (pre_q == PRE_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    // Leading-zero chain, built from the most significant digit downward.
    assign upper_zero[NUM_DIGITS-1] = (act_q[DW-1 -: 4] == 4'h0);
    for (genvar k = NUM_DIGITS - 2; k >= 0; k--) begin : g_lz
        assign upper_zero[k] = upper_zero[k+1] && (act_q[4*k +: 4] == 4'h0);
    end

    // Select the currently scanned digit's data and blanking inputs.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_uz  = 1'b0;
        cur_bm  = 1'b0;
        onehot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = act_q[4*k +: 4];
                cur_dp    = actdp_q[k];
                cur_uz    = upper_zero[k];
                cur_bm    = bus.blink_mask[k];
                onehot[k] = 1'b1;
            end
        end
        blank = (bus.blank_lz && (idx_q != '0) && cur_uz) || (phase_q && cur_bm);
        seg_d = blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~hex7(cur_nib) : hex7(cur_nib));
        dp_d  = blank ? DP_OFF  : (cur_dp ^ SEG_ACTIVE_LOW);
        ans_d = blank ? ANS_OFF : (ANODE_ACTIVE_LOW ? ~onehot : onehot);
    end

    // Scan, blink and shadow-load next state; active data only moves on wrap.
    always_comb begin
        pre_d    = tick ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        act_d    = act_q;
        actdp_d  = actdp_q;
        pend_d   = pend_q;
        penddp_d = penddp_q;
        pv_d     = pv_q;
        if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        if (wrap) begin
            if (bcnt_q == BLK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
            pv_d = 1'b0;
            if (bus.load) begin
                // A load landing on the frame boundary bypasses the shadow.
                act_d   = bus.din;
                actdp_d = bus.dp_in;
            end else if (pv_q) begin
                act_d   = pend_q;
                actdp_d = penddp_q;
            end
        end else if (bus.load) begin
            pend_d   = bus.din;
            penddp_d = bus.dp_in;
            pv_d     = 1'b1;
        end
    end

    // State and output registers; reset discards everything including pending data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            act_q    <= '0;
            actdp_q  <= '0;
            pend_q   <= '0;
            penddp_q <= '0;
            pv_q     <= 1'b0;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            ans_q    <= ANS_OFF;
            fd_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            act_q    <= act_d;
            actdp_q  <= actdp_d;
            pend_q   <= pend_d;
            penddp_q <= penddp_d;
            pv_q     <= pv_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            ans_q    <= ans_d;
            fd_q     <= wrap;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.ans        = ans_q;
    assign bus.frame_done = fd_q;
endmodule

// File: doc/display_mux_n.md
Name: display_mux_n

Overview:
- Parametrised successor to the team's fixed 4-digit scanned seven-segment driver.
- Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus with one anode per digit.
- Adds a tear-free shadow load, per-digit decimal points, leading-zero blanking, per-digit blink and a frame-done strobe.
- Sits between datapath/debug registers and the board's seven-segment pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16); digit 0 is rightmost.
- REFRESH_DIV, 100000, clk cycles each digit is held (>=2).
- BLINK_FRAMES, 32, full scan frames per blink phase (>=1).
- SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low-true.
- ANODE_ACTIVE_LOW, 1, 1 = ans driven low-true.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- din  in  4*NUM_DIGITS  hex nibbles; din[4k+3:4k] is digit k
- dp_in  in  NUM_DIGITS  decimal point per digit (1 = lit)
- load  in  1  capture din/dp_in into the pending shadow
- blank_lz  in  1  enable leading-zero blanking
- blink_mask  in  NUM_DIGITS  1 = digit blinks
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point, registered
- ans  out  NUM_DIGITS  one-hot anode select, registered
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset is sampled only on a clk edge where reset==0. On that edge, and with all outputs in their inactive polarity afterwards:
  - prescaler, idx, blink counter and blink_phase all 0;
  - active and pending registers 0; pend_valid 0;
  - seg all off, dp off, ans all inactive, frame_done 0.
- Reset asserted mid-frame or mid-blink abandons all state, including any pending load.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
- idx advances on tick and wraps from NUM_DIGITS-1 to 0.
- wrap = tick && idx==NUM_DIGITS-1.
- frame_done is registered: it goes high for exactly the cycle after wrap.
- Shadow load:
  - load==1 captures din/dp_in into pending and sets pend_valid; later loads overwrite.
  - On wrap with pend_valid, pending is copied to active and pend_valid clears.
  - load coincident with wrap: din/dp_in go straight to active and pend_valid stays 0.
  - Displayed data never changes mid-frame.
- Blink:
  - Blink counter increments on wrap. At BLINK_FRAMES-1 it resets to 0 and blink_phase toggles.
  - When blink_phase==1, digits with blink_mask[k]==1 are blanked.
  - blink_mask is sampled live; it is not shadowed.
- Leading-zero blanking: with blank_lz==1, digit k (k>0) is blanked iff active nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never LZ-blanked, so 0 shows as a single "0".
- Blanked digit: seg all off, dp off, and its anode is also inactive (whole digit dark).
- Output timing: seg/dp/ans reflect idx and active with exactly one cycle of latency (registered).
  - ans carries exactly one active bit except after reset, or when the current digit is blanked (then none).
  - The first anode activates on the cycle after reset releases.
- Decode, active-high, before polarity inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Polarity: the inversion selected by SEG_ACTIVE_LOW applies to seg and dp; ANODE_ACTIVE_LOW applies to ans.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, both polarity params =1.
- Reset/scan: hold reset=0 for 3 clks, then release with din=16'h1234, load pulsed once and blink_mask=0.
  - During reset: seg=7'h7F, ans=4'hF.
  - After the first wrap: ans steps 1110,1101,1011,0111, each held 4 clks; seg shows 4,3,2,1 (4 = ~1100110 = 0011001).
  - frame_done pulses once every 16 clks.
- Tear-free load: pulse load with din=16'hABCD mid-frame.
  - The remaining digits of that frame still show the old value.
  - ABCD appears starting with digit 0 of the next frame.
- Leading zeros: din=16'h0040, blank_lz=1.
  - Digits 3 and 2 dark (ans bit inactive, seg 7'h7F); digits 1/0 show 4/0.
  - din=0 shows only digit 0 = "0".
- Blink: blink_mask=4'b0001.
  - Digit 0 visible for 2 frames, dark for 2 frames, repeating; other digits unaffected.
- Decimal point and coincident load: dp_in=4'b0100 with load asserted exactly on the wrap cycle.
  - The next frame uses the new data immediately.
  - dp=0 only while ans=1011.
- Reset mid-frame: assert reset at idx=2, with a pending load outstanding.
  - All outputs go inactive on the next edge.
  - After release the scan restarts at digit 0 showing 0, and the pending data is discarded.
